road_game_engine: RTL and testbench

- Game-logic core of the lane racing game.
- Consumes the slow square-wave game tick from the clock divider (about 90 Hz at 50 MHz) and the debounced player buttons.
- Each tick scrolls a pseudo-random obstacle field down a LANES x ROWS grid and advances the score.
- Tracks the player car lane and detects collisions, lives and game state. The video/LED renderer downstream reads the outputs as plain registered state.

---
 rtl/road_game_engine.sv | 210 +++++++++++++++++++++
 tb/tb_road_game_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/road_game_engine.sv
// Game-logic core of the lane racing game.
// Scrolls an LFSR-generated obstacle field down a LANES x ROWS grid on each
// rising edge of the game tick. Also tracks the car lane, score, lives and
// game state. Every output is a plain register for the downstream renderer.
module road_game_engine #(
    parameter int         ROWS        = 8,
    parameter int         LANES       = 4,
    parameter int         LIVES       = 3,
    parameter int         CRASH_TICKS = 90,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    btn_left,
    input  logic                    btn_right,
    output logic [ROWS*LANES-1:0]   road,
    output logic [1:0]              car_lane,
    output logic [15:0]             score,
    output logic [1:0]              lives,
    output logic [1:0]              state,
    output logic                    crash
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int CW       = $clog2(CRASH_TICKS + 1);
    localparam int CAR_BASE = (ROWS - 1) * LANES;

    // Registered state
    logic                  tick_q, start_q, left_q, right_q;
    logic [7:0]            lfsr_r;
    logic [CW-1:0]         cnt_r;
    logic [ROWS*LANES-1:0] road_r;
    logic [1:0]            car_r;
    logic [15:0]           score_r;
    logic [1:0]            lives_r;
    state_t                state_r;
    logic                  crash_r;

    // Next-state values
    logic [7:0]            lfsr_n;
    logic [CW-1:0]         cnt_n;
    logic [ROWS*LANES-1:0] road_n;
    logic [1:0]            car_n;
    logic [15:0]           score_n;
    logic [1:0]            lives_n;
    state_t                state_n;
    logic                  crash_n;

    // Helpers
    logic                  step_s, start_e_s, left_e_s, right_e_s, hit_s;
    logic [LANES-1:0]      new_row_s;
    logic [7:0]            lfsr_adv_s;

    // Saturating score increment.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Rising-edge detection of the level inputs. The registers reset high,
    // so a level that is already high at reset release does not act.
    assign step_s    = tick & ~tick_q;
    assign start_e_s = start & ~start_q;
    assign left_e_s  = btn_left & ~left_q;
    assign right_e_s = btn_right & ~right_q;

    // The car occupies lane car_r of the bottom row.
    assign hit_s      = road_r[CAR_BASE + int'(car_r)];
    assign lfsr_adv_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};

    // New spawn row: one obstacle in lane lfsr[1:0] when lfsr[2] is set.
    always_comb begin
        new_row_s = '0;
        if (lfsr_r[2]) begin
            new_row_s[lfsr_r[1:0]] = 1'b1;
        end else begin
            new_row_s = '0;
        end
    end

    // Game state machine and playfield datapath (next-state logic).
    always_comb begin
        lfsr_n  = lfsr_r;
        cnt_n   = cnt_r;
        road_n  = road_r;
        car_n   = car_r;
        score_n = score_r;
        lives_n = lives_r;
        state_n = state_r;
        crash_n = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start_e_s) begin
                    state_n = ST_RUN;
                    road_n  = '0;
                    car_n   = 2'd1;
                    score_n = 16'd0;
                    lives_n = 2'(LIVES);
                end else begin
                    state_n = state_r;
                end
            end
            ST_RUN: begin
                if (hit_s) begin
                    // A collision discards this cycle's step and button edges.
                    crash_n = 1'b1;
                    road_n  = '0;
                    car_n   = 2'd1;
                    if (lives_r == 2'd1) begin
                        lives_n = 2'd0;
                        state_n = ST_OVER;
                    end else begin
                        lives_n = lives_r - 2'd1;
                        state_n = ST_CRASH;
                        cnt_n   = '0;
                    end
                end else begin
                    // Opposing edges in the same cycle cancel out.
                    if (left_e_s && !right_e_s) begin
                        if (car_r != 2'd0) begin
                            car_n = car_r - 2'd1;
                        end else begin
                            car_n = car_r;
                        end
                    end else if (right_e_s && !left_e_s) begin
                        if (car_r != 2'(LANES - 1)) begin
                            car_n = car_r + 2'd1;
                        end else begin
                            car_n = car_r;
                        end
                    end else begin
                        car_n = car_r;
                    end
                    if (step_s) begin
                        road_n  = {road_r[CAR_BASE-1:0], new_row_s};
                        lfsr_n  = lfsr_adv_s;
                        score_n = sat_inc(score_r);
                    end else begin
                        road_n = road_r;
                    end
                end
            end
            ST_CRASH: begin
                // Playfield frozen and empty until the penalty time elapses.
                road_n = '0;
                if (cnt_r == CW'(CRASH_TICKS)) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                end else if (step_s) begin
                    cnt_n = cnt_r + CW'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and edge-detect registers.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            tick_q  <= 1'b1;
            start_q <= 1'b1;
            left_q  <= 1'b1;
            right_q <= 1'b1;
            lfsr_r  <= LFSR_SEED;
            cnt_r   <= '0;
            road_r  <= '0;
            car_r   <= 2'd1;
            score_r <= 16'd0;
            lives_r <= 2'(LIVES);
            state_r <= ST_IDLE;
            crash_r <= 1'b0;
        end else begin
            tick_q  <= tick;
            start_q <= start;
            left_q  <= btn_left;
            right_q <= btn_right;
            lfsr_r  <= lfsr_n;
            cnt_r   <= cnt_n;
            road_r  <= road_n;
            car_r   <= car_n;
            score_r <= score_n;
            lives_r <= lives_n;
            state_r <= state_n;
            crash_r <= crash_n;
        end
    end

    assign road     = road_r;
    assign car_lane = car_r;
    assign score    = score_r;
    assign lives    = lives_r;
    assign state    = state_r;
    assign crash    = crash_r;

endmodule

// File: tb/tb_road_game_engine.sv
// Directed self-checking bench for road_game_engine. Inputs change on the
// falling clock edge and outputs are sampled there, half a cycle after the
// rising edge that updated them.
module tb_road_game_engine;

    logic        clock_in = 1'b0;
    logic        reset    = 1'b1;
    logic        tick     = 1'b0;
    logic        start    = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic [31:0] road;
    logic [1:0]  car_lane;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [1:0]  state;
    logic        crash;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_steps;

    road_game_engine dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .road      (road),
        .car_lane  (car_lane),
        .score     (score),
        .lives     (lives),
        .state     (state),
        .crash     (crash)
    );

    // 10-time-unit clock, rising edges at 5, 15, ...
    always #5 clock_in = ~clock_in;

    // Single comparison point: counts and reports.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise tick; afterwards the post-step state is visible.
    task automatic step_hi();
        tick = 1'b1;
        @(negedge clock_in);
    endtask

    // Lower tick; any collision from the preceding step is visible afterwards.
    task automatic step_lo();
        tick = 1'b0;
        @(negedge clock_in);
    endtask

    task automatic full_step();
        step_hi();
        step_lo();
    endtask

    task automatic press(input logic l, input logic r);
        btn_left  = l;
        btn_right = r;
        @(negedge clock_in);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        @(negedge clock_in);
    endtask

    task automatic press_start();
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        @(negedge clock_in);
    endtask

    // Step until a crash pulse is seen, bounded by max_steps.
    task automatic step_until_crash(input int max_steps, output int n);
        n = 0;
        for (int i = 0; i < max_steps; i++) begin
            full_step();
            n++;
            if (crash) break;
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock_in);
        reset = 1'b0;
        @(negedge clock_in);

        // Reset state
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_road", road, 32'd0);
        check_val("rst_car", 32'(car_lane), 32'd1);
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_lives", 32'(lives), 32'd3);
        check_val("rst_crash", 32'(crash), 32'd0);

        // Ticks in IDLE change nothing, LFSR included
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            repeat (2) @(negedge clock_in);
            tick = 1'b0;
            repeat (2) @(negedge clock_in);
        end
        check_val("idle_state", 32'(state), 32'd0);
        check_val("idle_road", road, 32'd0);
        check_val("idle_score", 32'(score), 32'd0);
        check_val("idle_lives", 32'(lives), 32'd3);
        check_val("idle_lfsr", 32'(dut.lfsr_r), 32'hA5);

        // Start a game
        press_start();
        check_val("start_state", 32'(state), 32'd1);

        // First step spawns lane 1 from seed A5
        step_hi();
        check_val("step1_row0", 32'(road[3:0]), 32'b0010);
        check_val("step1_lfsr", 32'(dut.lfsr_r), 32'h4A);
        check_val("step1_score", 32'(score), 32'd1);
        step_lo();
        for (int i = 2; i <= 7; i++) full_step();
        step_hi();
        check_val("step8_road", road, 32'h2020_1008);
        check_val("step8_score", 32'(score), 32'd8);
        step_lo();
        check_val("crash1_pulse", 32'(crash), 32'd1);
        check_val("crash1_state", 32'(state), 32'd2);
        check_val("crash1_lives", 32'(lives), 32'd2);
        check_val("crash1_score", 32'(score), 32'd8);
        check_val("crash1_road", road, 32'd0);
        check_val("crash1_car", 32'(car_lane), 32'd1);
        @(negedge clock_in);
        check_val("crash1_pulse_end", 32'(crash), 32'd0);

        // CRASH penalty: 90 steps, RUN on the clock after the 90th
        for (int i = 0; i < 89; i++) full_step();
        check_val("pen89_state", 32'(state), 32'd2);
        check_val("pen89_score", 32'(score), 32'd8);
        check_val("pen89_road", road, 32'd0);
        step_hi();
        check_val("pen90_state", 32'(state), 32'd2);
        step_lo();
        check_val("pen_resume", 32'(state), 32'd1);

        // Second collision: lane-1 obstacle from lfsr 9D arrives at step 9
        step_until_crash(40, n_steps);
        check_val("crash2_steps", 32'(n_steps), 32'd9);
        check_val("crash2_lives", 32'(lives), 32'd1);
        check_val("crash2_state", 32'(state), 32'd2);
        check_val("crash2_score", 32'(score), 32'd17);
        for (int i = 0; i < 90; i++) full_step();
        check_val("pen2_resume", 32'(state), 32'd1);

        // Third collision: lane-1 obstacle from lfsr 3D arrives at step 13
        step_until_crash(40, n_steps);
        check_val("crash3_steps", 32'(n_steps), 32'd13);
        check_val("over_state", 32'(state), 32'd3);
        check_val("over_lives", 32'(lives), 32'd0);
        check_val("over_score", 32'(score), 32'd30);
        full_step();
        full_step();
        press(1'b1, 1'b0);
        check_val("over_frozen_score", 32'(score), 32'd30);
        check_val("over_frozen_state", 32'(state), 32'd3);
        check_val("over_car_ignored", 32'(car_lane), 32'd1);

        // Restart from OVER
        press_start();
        check_val("restart_state", 32'(state), 32'd1);
        check_val("restart_score", 32'(score), 32'd0);
        check_val("restart_lives", 32'(lives), 32'd3);
        check_val("restart_road", road, 32'd0);

        // Movement and lane limits
        press(1'b1, 1'b0);
        check_val("mv_left", 32'(car_lane), 32'd0);
        press(1'b1, 1'b0);
        check_val("mv_left_edge", 32'(car_lane), 32'd0);
        press(1'b0, 1'b1);
        check_val("mv_right", 32'(car_lane), 32'd1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check_val("mv_right3", 32'(car_lane), 32'd3);
        press(1'b0, 1'b1);
        check_val("mv_right_edge", 32'(car_lane), 32'd3);
        press(1'b1, 1'b1);
        check_val("mv_both", 32'(car_lane), 32'd3);
        btn_left = 1'b1;
        repeat (100) @(negedge clock_in);
        btn_left = 1'b0;
        @(negedge clock_in);
        check_val("mv_held", 32'(car_lane), 32'd2);

        // Score saturation
        force dut.score_r = 16'hFFFE;
        @(negedge clock_in);
        release dut.score_r;
        @(negedge clock_in);
        step_hi();
        check_val("sat_first", 32'(score), 32'hFFFF);
        step_lo();
        full_step();
        check_val("sat_hold", 32'(score), 32'hFFFF);

        // Mid-game asynchronous reset with a nonzero road
        reset = 1'b1;
        @(negedge clock_in);
        reset = 1'b0;
        @(negedge clock_in);
        press_start();
        step_hi();
        check_val("pre_rst_road", road, 32'h0000_0002);
        #2 reset = 1'b1;
        #1;
        check_val("arst_road", road, 32'd0);
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_score", 32'(score), 32'd0);
        check_val("arst_car", 32'(car_lane), 32'd1);
        check_val("arst_lives", 32'(lives), 32'd3);
        check_val("arst_crash", 32'(crash), 32'd0);

        // tick held high through reset release must not step
        @(negedge clock_in);
        reset = 1'b0;
        @(negedge clock_in);
        press_start();
        repeat (4) @(negedge clock_in);
        check_val("held_tick_state", 32'(state), 32'd1);
        check_val("held_tick_road", road, 32'd0);
        check_val("held_tick_score", 32'(score), 32'd0);
        step_lo();
        step_hi();
        check_val("tick_after_rst_road", road, 32'h0000_0002);
        check_val("tick_after_rst_score", 32'(score), 32'd1);
        step_lo();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
